// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Executes MULT, MULTU, DIV, DIVU (WIDTH+1 cycles each) and MTHI/MTLO (1 cycle).
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start_i  - request strobe, honoured only while busy_o is low
//   op_i     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   src_a_i  - rs: multiplicand / dividend / MTHI-MTLO data
//   src_b_i  - rt: multiplier / divisor
//   busy_o   - multi-cycle operation in flight
//   done_o   - one-cycle pulse, HI/LO were updated on the preceding edge
//   hi_o     - HI register
//   lo_o     - LO register
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shared working register: {partial product hi, multiplier} or {remainder, dividend/quotient}
  logic [AW-1:0]    acc_q, acc_d;
  // Multiplicand for MUL, divisor for DIV (magnitudes for signed ops)
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder (dividend sign)
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes at the accept edge
  logic             is_signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  // Datapath step terms
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem_next;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    acc_neg;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_signed_op = ~op_i[0];
  assign a_neg        = is_signed_op & src_a_i[WIDTH-1];
  assign b_neg        = is_signed_op & src_b_i[WIDTH-1];
  assign a_abs        = a_neg ? (~src_a_i + WIDTH'(1)) : src_a_i;
  assign b_abs        = b_neg ? (~src_b_i + WIDTH'(1)) : src_b_i;

  // Shift-add: add multiplicand to the upper half when the current multiplier bit is set, shift right
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, {WIDTH{1'b0}}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: the remainder stays below the divisor, so WIDTH bits hold it between steps
  assign div_shift    = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff     = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_fits     = ~div_diff[WIDTH+1];
  assign div_rem_next = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next     = {div_rem_next, acc_q[WIDTH-2:0], div_fits};

  // Sign correction terms
  assign acc_neg = ~acc_q + AW'(1);
  assign quo_fix = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix = neg_hi_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MTHI: begin
              hi_d   = src_a_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = src_a_i;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              opnd_d   = a_abs;
              acc_d    = {{WIDTH{1'b0}}, b_abs};
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              opnd_d   = b_abs;
              acc_d    = {{WIDTH{1'b0}}, a_abs};
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
              is_div_d = 1'b1;
              cnt_d    = CNT_W'(WIDTH);
              busy_d   = 1'b1;
              state_d  = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else if (neg_lo_q) begin
          hi_d = acc_neg[AW-1:WIDTH];
          lo_d = acc_neg[WIDTH-1:0];
        end else begin
          hi_d = acc_q[AW-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32). Expected {HI,LO} values are queued
// when a request is issued and compared by a scoreboard process on every done_o pulse.
module tb_mips_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] src_a_i = '0;
  logic [W-1:0] src_b_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int           tests = 0;
  int           fails = 0;
  logic [63:0]  sb[$];
  logic [63:0]  mon_exp;
  logic [31:0]  m_hi = '0;
  logic [31:0]  m_lo = '0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start_i),
    .op_i    (op_i),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n && done_o) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done_o=1 with nothing pending (hi=%h lo=%h)", hi_o, lo_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({hi_o, lo_o} !== mon_exp) begin
          fails++;
          $display("FAIL result: got hi=%h lo=%h, want hi=%h lo=%h",
                   hi_o, lo_o, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  // Drive one start cycle from a negedge; operands are scrambled afterwards
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp);
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    start_i = 1'b1;
    if (push) begin
      sb.push_back(exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
    @(negedge clk);
    start_i = 1'b0;
    src_a_i = $urandom;
    src_b_i = $urandom;
  endtask

  // Wait (bounded) for done_o, counting busy cycles and whether HI/LO stayed put meanwhile
  task automatic wait_done(output int busy_cycles, output bit held, output bit timed_out);
    logic [31:0] h0, l0;
    h0 = hi_o;
    l0 = lo_o;
    busy_cycles = 0;
    held = 1'b1;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
      if (busy_o) busy_cycles++;
      if (hi_o !== h0 || lo_o !== l0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int c; bit h, t;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("FAIL reset_hold: busy=%b done=%b hi=%h lo=%h, want all 0", busy_o, done_o, hi_o, lo_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
    issue(3'b100, 32'h5555_5555, 32'h0, 1'b1, {32'h5555_5555, m_lo});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0) begin fails++; $display("FAIL pre_reset_timeout: timed_out=%b want 0", t); end
    @(posedge clk);
    #3;
    tests++;
    if (hi_o !== 32'h5555_5555) begin
      fails++; $display("FAIL pre_reset_hi: hi=%h want 55555555", hi_o);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy_o, done_o, hi_o, lo_o);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mt();
    int c; bit h, t;
    issue(3'b100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, {32'hDEAD_BEEF, m_lo});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 0) begin
      fails++; $display("FAIL mthi_latency: timed_out=%b busy_cycles=%0d, want 0 and 0", t, c);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin fails++; $display("FAIL mthi_pulse: done=%b want 0", done_o); end
    issue(3'b101, 32'h1234_5678, 32'h2222_2222, 1'b1, {m_hi, 32'h1234_5678});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 0) begin
      fails++; $display("FAIL mtlo_latency: timed_out=%b busy_cycles=%0d, want 0 and 0", t, c);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0 || hi_o !== 32'hDEAD_BEEF || lo_o !== 32'h1234_5678) begin
      fails++;
      $display("FAIL mt_regs: done=%b hi=%h lo=%h, want 0 deadbeef 12345678", done_o, hi_o, lo_o);
    end
    // 11x is a no-op: no done, no busy, registers untouched
    issue(3'b110, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'hDEAD_BEEF || lo_o !== 32'h1234_5678) begin
      fails++;
      $display("FAIL nop: done=%b busy=%b hi=%h lo=%h, want 0 0 deadbeef 12345678", done_o, busy_o, hi_o, lo_o);
    end
  endtask

  task automatic test_mul();
    int c; bit h, t;
    issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33 || h !== 1'b1) begin
      fails++; $display("FAIL mult_timing: timed_out=%b busy=%0d held=%b, want 0 33 1", t, c, h);
    end
    issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, {32'h0000_0002, 32'hFFFF_FFFA});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33 || h !== 1'b1) begin
      fails++; $display("FAIL multu_timing: timed_out=%b busy=%0d held=%b, want 0 33 1", t, c, h);
    end
  endtask

  task automatic test_div();
    int c; bit h, t;
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33 || h !== 1'b1) begin
      fails++; $display("FAIL div_timing: timed_out=%b busy=%0d held=%b, want 0 33 1", t, c, h);
    end
    issue(3'b011, 32'd7, 32'd2, 1'b1, {32'd1, 32'd3});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33) begin
      fails++; $display("FAIL divu_timing: timed_out=%b busy=%0d, want 0 33", t, c);
    end
  endtask

  task automatic test_div_corner();
    int c; bit h, t;
    issue(3'b011, 32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFF_FFFF});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33) begin
      fails++; $display("FAIL divu_zero_timing: timed_out=%b busy=%0d, want 0 33", t, c);
    end
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0) begin fails++; $display("FAIL div_ovf_timeout: timed_out=%b want 0", t); end
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'h0000_0001});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0) begin fails++; $display("FAIL div_neg_zero_timeout: timed_out=%b want 0", t); end
  endtask

  task automatic test_back_to_back();
    int c; bit h, t;
    issue(3'b001, 32'd3, 32'd4, 1'b1, {32'd0, 32'd12});
    repeat (3) @(negedge clk);
    // Request while busy must be dropped
    issue(3'b011, 32'd100, 32'd7, 1'b0, 64'h0);
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || h !== 1'b1) begin
      fails++; $display("FAIL busy_ignore: timed_out=%b held=%b, want 0 1", t, h);
    end
    // Start in the done cycle is accepted
    issue(3'b011, 32'd7, 32'd2, 1'b1, {32'd1, 32'd3});
    tests++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy=%b want 1", busy_o); end
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || c !== 33 || h !== 1'b1) begin
      fails++; $display("FAIL b2b_timing: timed_out=%b busy=%0d held=%b, want 0 33 1", t, c, h);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL b2b_quiet: done=%b busy=%b, want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_random();
    int c; bit h, t;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    longint      sa, sbv;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (op[1]) begin
        if (i[0]) b = b >> 20;
        if (b == 0) b = 32'd3;
        if (a == 32'h8000_0000) a = 32'h8000_0001;
      end
      sa  = $signed(a);
      sbv = $signed(b);
      case (op)
        3'b000:  exp = 64'(sa * sbv);
        3'b001:  exp = {32'h0, a} * {32'h0, b};
        3'b010:  exp = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        default: exp = {a % b, a / b};
      endcase
      issue(op, a, b, 1'b1, exp);
      wait_done(c, h, t);
      tests++;
      if (t !== 1'b0 || c !== 33) begin
        fails++; $display("FAIL rand_timing[%0d]: op=%0d timed_out=%b busy=%0d, want 0 33", i, op, t, c);
      end
    end
  endtask

  task automatic test_reset_abort();
    int c; bit h, t;
    int bad;
    issue(3'b100, 32'hAAAA_AAAA, 32'h0, 1'b1, {32'hAAAA_AAAA, m_lo});
    wait_done(c, h, t);
    issue(3'b101, 32'hAAAA_AAAA, 32'h0, 1'b1, {m_hi, 32'hAAAA_AAAA});
    wait_done(c, h, t);
    tests++;
    if (t !== 1'b0 || hi_o !== 32'hAAAA_AAAA) begin
      fails++; $display("FAIL abort_setup: timed_out=%b hi=%h, want 0 aaaaaaaa", t, hi_o);
    end
    issue(3'b000, 32'd7, 32'd9, 1'b1, {32'd0, 32'd63});
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
      fails++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy_o, done_o, hi_o, lo_o);
    end
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL abort_quiet: %0d cycles with activity after release, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mul();
    test_div();
    test_div_corner();
    test_back_to_back();
    test_random();
    test_reset_abort();
    tests++;
    if (sb.size() !== 0) begin
      fails++; $display("FAIL sb_drain: %0d results still pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
